// File: rtl/stack_control.sv
// ---------------------------------------------------------------------------
// stack_control
// Sequencer for a falling-block stacking game. It draws a 4x4 block, holds it
// on screen for DELAY cycles, erases it and steps it sideways. A press of go
// locks the block onto the current row, and after MAX_LEVEL locked rows the
// game ends.
//
// Ports
//   clk                 : system clock, rising edge active
//   reset               : asynchronous reset, active low
//   go                  : player drop button, active high, synchronous to clk
//   ld_x                : one-cycle pulse that steps the block horizontally
//   ld_y                : one-cycle pulse that steps the block row
//   level_up_true       : asserted together with ld_y
//   colour_erase_enable : forces the drawn colour to black
//   plot                : VGA write enable
//   offset[3:0]         : pixel index in the block, [1:0]=x and [3:2]=y
//   level[4:0]          : count of locked rows
//   done                : game over
// ---------------------------------------------------------------------------
module stack_control #(
    parameter int DELAY     = 12500000,
    parameter int MAX_LEVEL = 29
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       go,
    output logic       ld_x,
    output logic       ld_y,
    output logic       level_up_true,
    output logic       colour_erase_enable,
    output logic       plot,
    output logic [3:0] offset,
    output logic [4:0] level,
    output logic       done
);

    // DELAY >= 2, so the counter is always at least one bit wide.
    localparam int              CNT_W     = $clog2(DELAY);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DELAY - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [4:0]       LEVEL_MAX = 5'(MAX_LEVEL);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DRAW  = 3'd1,
        S_WAIT  = 3'd2,
        S_ERASE = 3'd3,
        S_MOVE  = 3'd4,
        S_LOCK  = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       offset_q, offset_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       level_q, level_d;
    logic             drop_q, drop_d;
    logic             go_q;
    logic             go_rise_s;
    logic [4:0]       level_inc_s;

    // State, counters and go history; reset aborts to IDLE at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            offset_q <= 4'd0;
            cnt_q    <= CNT_ZERO;
            level_q  <= 5'd0;
            drop_q   <= 1'b0;
            go_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            offset_q <= offset_d;
            cnt_q    <= cnt_d;
            level_q  <= level_d;
            drop_q   <= drop_d;
            go_q     <= go;
        end
    end

    // Next-state logic, pixel/delay counters, level and drop request.
    always_comb begin
        state_d     = state_q;
        offset_d    = offset_q;
        cnt_d       = cnt_q;
        level_d     = level_q;
        drop_d      = drop_q;
        go_rise_s   = go & ~go_q;
        level_inc_s = (level_q == LEVEL_MAX) ? level_q : (level_q + 5'd1);

        case (state_q)
            S_IDLE: begin
                // A press here only starts the game; it never requests a drop.
                if (go_rise_s) begin
                    state_d = S_DRAW;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DRAW: begin
                drop_d   = drop_q | go_rise_s;
                offset_d = offset_q + 4'd1;   // wraps 15 -> 0 on exit
                if (offset_q == 4'd15) begin
                    state_d = S_WAIT;
                end else begin
                    state_d = S_DRAW;
                end
            end
            S_WAIT: begin
                drop_d = drop_q | go_rise_s;
                // A pending drop is only honoured here, with the block fully drawn.
                if (drop_q) begin
                    state_d = S_LOCK;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_ERASE;
                    cnt_d   = CNT_ZERO;
                end else begin
                    state_d = S_WAIT;
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            S_ERASE: begin
                drop_d   = drop_q | go_rise_s;
                offset_d = offset_q + 4'd1;
                if (offset_q == 4'd15) begin
                    state_d = S_MOVE;
                end else begin
                    state_d = S_ERASE;
                end
            end
            S_MOVE: begin
                drop_d  = drop_q | go_rise_s;
                state_d = S_DRAW;
            end
            S_LOCK: begin
                // Clearing wins over a press arriving in this same cycle.
                drop_d  = 1'b0;
                level_d = level_inc_s;
                if (level_inc_s == LEVEL_MAX) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_DRAW;
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d  = S_IDLE;
                offset_d = 4'd0;
                cnt_d    = CNT_ZERO;
                drop_d   = 1'b0;
            end
        endcase
    end

    // Moore decode of the registered state onto the strobes.
    always_comb begin
        plot                = 1'b0;
        colour_erase_enable = 1'b0;
        ld_x                = 1'b0;
        ld_y                = 1'b0;
        level_up_true       = 1'b0;
        done                = 1'b0;
        case (state_q)
            S_DRAW:  plot = 1'b1;
            S_ERASE: begin
                plot                = 1'b1;
                colour_erase_enable = 1'b1;
            end
            S_MOVE:  ld_x = 1'b1;
            S_LOCK: begin
                ld_y          = 1'b1;
                level_up_true = 1'b1;
            end
            S_DONE:  done = 1'b1;
            default: plot = 1'b0;
        endcase
    end

    assign offset = offset_q;
    assign level  = level_q;

endmodule

// File: doc/stack_control.md
STACK_CONTROL -- requirements
Module: stack_control

Interface
REQ-001 Parameters: DELAY, default 12500000, number of clk cycles a drawn block stays on screen before it moves; minimum 2.
REQ-002 Parameters: MAX_LEVEL, default 29, number of locked rows that ends the game; range 1..31.
REQ-003 Ports: clk  input  1  system clock; all state changes on its rising edge.
REQ-004 Ports: reset  input  1  asynchronous, active-low reset.
REQ-005 Ports: go  input  1  player drop button, active-high, synchronous to clk.
REQ-006 Ports: ld_x  output  1  one-cycle pulse that steps the block position horizontally.
REQ-007 Ports: ld_y  output  1  one-cycle pulse that steps the block row.
REQ-008 Ports: level_up_true  output  1  asserted together with ld_y.
REQ-009 Ports: colour_erase_enable  output  1  forces the drawn colour to black.
REQ-010 Ports: plot  output  1  VGA write enable.
REQ-011 Ports: offset  output  4  pixel index within the 4x4 block; bits[1:0] give the x offset and bits[3:2] give the y offset.
REQ-012 Ports: level  output  5  count of locked rows.
REQ-013 Ports: done  output  1  game over.

Function
REQ-014 The block SHALL detect a go rising edge as go=1 with the previous sample go_q=0, using a single register for go_q.
REQ-015 The block SHALL implement the states IDLE, DRAW, WAIT, ERASE, MOVE, LOCK and DONE.
REQ-016 IDLE: on a go rising edge, the next state SHALL be DRAW; otherwise the block SHALL stay in IDLE.
REQ-017 DRAW: plot=1 and offset SHALL count 0..15, one step per cycle; after offset=15 the next state SHALL be WAIT and offset SHALL return to 0.
REQ-018 WAIT: a delay counter SHALL count from 0; if drop_req=1 the next state SHALL be LOCK; else, when the counter reaches DELAY-1, the next state SHALL be ERASE; the counter SHALL clear on exit.
REQ-019 ERASE: plot=1 and colour_erase_enable=1 while offset counts 0..15; the next state SHALL then be MOVE.
REQ-020 MOVE: ld_x=1 for exactly one cycle; the next state SHALL be DRAW.
REQ-021 LOCK: ld_y=1 and level_up_true=1 for exactly one cycle; level SHALL increment and drop_req SHALL clear.
REQ-022 Leaving LOCK: if the incremented level equals MAX_LEVEL the next state SHALL be DONE; otherwise it SHALL be DRAW, so the new row is drawn with the block left unerased.
REQ-023 DONE: done=1 and every other strobe 0; the block SHALL remain in DONE until reset, and go SHALL be ignored.
REQ-024 drop_req SHALL be set by a go rising edge in DRAW, WAIT, ERASE or MOVE, and SHALL hold until LOCK.
REQ-025 drop_req SHALL be honoured only from WAIT, so a partially drawn or erased block is never abandoned.
REQ-026 A go rising edge occurring in the same cycle that LOCK clears drop_req SHALL be dropped.
REQ-027 A go rising edge in IDLE SHALL NOT set drop_req.
REQ-028 Strobes SHALL be Moore decodes of the registered state; plot, colour_erase_enable, ld_x and ld_y SHALL never be asserted in the same cycle as each other, except that plot and colour_erase_enable are asserted together in ERASE.
REQ-029 offset SHALL be 0 in every state other than DRAW and ERASE.
REQ-030 The delay counter SHALL be wide enough for DELAY-1 and SHALL have no wrap-around in WAIT.
REQ-031 level SHALL saturate at MAX_LEVEL.
REQ-032 Latency: from a go rising edge in IDLE, the first plot SHALL occur 1 cycle later.
REQ-033 A full move period SHALL be 16+DELAY+16+1 cycles.

Reset
REQ-034 While reset=0, asynchronously: state=IDLE, offset=0, level=0, delay counter=0, drop_req=0, go_q=0, and all outputs 0.
REQ-035 When reset is asserted mid-operation (any state), the block SHALL abort immediately to IDLE with no further strobes.
REQ-036 Operation SHALL resume on the first clk edge after reset=1.

Verification (DELAY=4, MAX_LEVEL=3)
REQ-037 Reset, then go pulse at cycle 10 -> plot=1 at cycles 11..26 with offset 0..15; WAIT at cycles 27..30; ERASE at cycles 31..46 with colour_erase_enable=1; ld_x=1 at cycle 47 only; DRAW resumes at cycle 48.
REQ-038 go pulse during the 5th DRAW cycle -> DRAW completes all 16 pixels, then one WAIT cycle, then LOCK (ld_y=1, level_up_true=1 for one cycle), level=1, then DRAW with no ERASE.
REQ-039 go pulse during ERASE -> ERASE and MOVE complete, DRAW runs 16 cycles, then WAIT for one cycle, then LOCK.
REQ-040 Three drops -> level steps 1, 2, 3; after the third LOCK, done=1 and stays 1 with all strobes 0 despite further go pulses.
REQ-041 go held high for 100 cycles from IDLE -> exactly one start and no drop; LOCK occurs only after go is released and pressed again.
REQ-042 reset=0 asserted mid-ERASE at offset 7 -> plot, colour_erase_enable and offset go to 0 immediately; state=IDLE, and no ld_x pulse follows.
